// File: rtl/mux_arb_pkg.sv
// Shared constants for the round-robin mux-select arbiter: sizes, FSM encodings
// and the index-to-one-hot helper.
package mux_arb_pkg;

  localparam int NUM_REQ   = 4;
  localparam int SEL_WIDTH = 2;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_RELEASE = 2'd2;

  function automatic logic [NUM_REQ-1:0] sel_to_onehot(input logic [SEL_WIDTH-1:0] idx);
    sel_to_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: rotate the request vector so PTR sits at bit 0,
// take the lowest set bit, then map that offset back to a requester index.
module rr_priority_pick
  import mux_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0]   req_i,
  input  logic [SEL_WIDTH-1:0] ptr_i,
  output logic [SEL_WIDTH-1:0] winner_o,
  output logic                 found_o
);

  logic [NUM_REQ-1:0]   rot_s;
  logic [SEL_WIDTH-1:0] off_s;

  // Rotate so bit j of rot_s is requester (ptr + j) mod NUM_REQ.
  always_comb begin
    rot_s = {NUM_REQ{1'b0}};
    for (int j = 0; j < NUM_REQ; j++) begin
      rot_s[j] = req_i[SEL_WIDTH'(j) + ptr_i];
    end
  end

  // Priority-encode: the descending scan leaves the lowest set offset in off_s.
  always_comb begin
    off_s = {SEL_WIDTH{1'b0}};
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      off_s = rot_s[j] ? SEL_WIDTH'(j) : off_s;
    end
  end

  assign winner_o = off_s + ptr_i;
  assign found_o  = |req_i;

endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a 4:1 datapath mux; an owner keeps the
// mux until it drops its request. Optional forced release under macro ARB_TIMEOUT_EN.
module mux_sel_arbiter
  import mux_arb_pkg::*;
#(
  parameter int MAX_HOLD  = 16,
  parameter int CNT_WIDTH = 5
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NUM_REQ-1:0]   req_i,
  output logic [NUM_REQ-1:0]   gnt_o,
  output logic [SEL_WIDTH-1:0] sel_o,
  output logic                 sel_valid_o,
  output logic                 busy_o,
  output logic                 timeout_o
);

  if (MAX_HOLD < 2 || MAX_HOLD > 31 || (MAX_HOLD - 1) >= (1 << CNT_WIDTH)) begin : g_cfg_err
    $error("mux_sel_arbiter: MAX_HOLD must be 2..31 and fit in CNT_WIDTH bits");
  end

  logic [1:0]           state_q, state_d;
  logic [SEL_WIDTH-1:0] ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [SEL_WIDTH-1:0] sel_q, sel_d;
  logic                 valid_q, valid_d;
  logic                 busy_q, busy_d;

  logic [SEL_WIDTH-1:0] win_s;
  logic                 found_s;
  logic                 req_owner_s;
  logic                 force_rel_s;

  rr_priority_pick u_pick (
    .req_i    (req_i),
    .ptr_i    (ptr_q),
    .winner_o (win_s),
    .found_o  (found_s)
  );

  assign req_owner_s = req_i[sel_q];

`ifdef ARB_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] HOLD_LAST = CNT_WIDTH'(MAX_HOLD - 1);

  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic                 timeout_q, timeout_d;

  // Forced release only matters when someone else is actually waiting.
  assign force_rel_s = (hold_q == HOLD_LAST) && ((req_i & ~gnt_q) != {NUM_REQ{1'b0}});
  assign timeout_d   = (state_q == ST_GRANT) && req_owner_s && force_rel_s;

  // Hold counter: cleared on each new grant, saturates at MAX_HOLD-1 while granted.
  always_comb begin
    hold_d = hold_q;
    if (state_q == ST_IDLE && found_s) begin
      hold_d = {CNT_WIDTH{1'b0}};
    end else if (state_q == ST_GRANT && hold_q != HOLD_LAST) begin
      hold_d = hold_q + CNT_WIDTH'(1);
    end else begin
      hold_d = hold_q;
    end
  end

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hold_q    <= {CNT_WIDTH{1'b0}};
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign force_rel_s = 1'b0;
  assign timeout_o   = 1'b0;
`endif

  // Arbitration FSM; SEL only moves on IDLE->GRANT so it is stable while valid.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    valid_d = valid_q;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          state_d = ST_GRANT;
          gnt_d   = sel_to_onehot(win_s);
          sel_d   = win_s;
          valid_d = 1'b1;
          busy_d  = 1'b1;
          ptr_d   = win_s + SEL_WIDTH'(1);
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (!req_owner_s || force_rel_s) begin
          state_d = ST_RELEASE;
          gnt_d   = {NUM_REQ{1'b0}};
          valid_d = 1'b0;
        end else begin
          state_d = ST_GRANT;
        end
      end
      ST_RELEASE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        gnt_d   = {NUM_REQ{1'b0}};
        valid_d = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State, pointer and registered outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= {SEL_WIDTH{1'b0}};
      gnt_q   <= {NUM_REQ{1'b0}};
      sel_q   <= {SEL_WIDTH{1'b0}};
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign sel_o       = sel_q;
  assign sel_valid_o = valid_q;
  assign busy_o      = busy_q;

endmodule
